// File: rtl/conv_frame_if.sv
// Signal bundle between conv_frame_ctrl (master) and the frame memory, conv_proc
// and result memory around it (slave).
// Handshake: start is taken only while busy=0 and done pulses for one cycle when the
// frame ends; rd_data is valid exactly one cycle after rd_en; wr_en is a one-cycle
// strobe with wr_addr/wr_data valid in that same cycle; there is no backpressure.
interface conv_frame_if #(
    parameter int AW = 6
);
    logic              start;
    logic              busy;
    logic              done;
    logic              k_we;
    logic [3:0]        k_addr;
    logic [7:0]        k_data;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [7:0]        rd_data;
    logic [8:0][7:0]   data_mat;
    logic [8:0][7:0]   kernal;
    logic [7:0]        w_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [7:0]        wr_data;

    modport master (
        input  start, k_we, k_addr, k_data, rd_data, w_data,
        output busy, done, rd_en, rd_addr, data_mat, kernal, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, k_we, k_addr, k_data, rd_data, w_data,
        input  busy, done, rd_en, rd_addr, data_mat, kernal, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 convolution datapath: fetches every valid window,
// holds a locked kernel, and writes one conv_proc result per window in raster order.
module conv_frame_ctrl #(
    parameter int  IMG_W    = 8,
    parameter int  IMG_H    = 8,
    parameter int  PROC_LAT = 0,
    localparam int AW       = $clog2(IMG_W * IMG_H)
) (
    input  logic               clk,
    input  logic               reset,
    conv_frame_if.master       bus,
    output logic [2:0]         state_dbg
);

    localparam int WCW = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;

    // S_IDLE encodes as 0 on state_dbg.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state;
    logic [AW-1:0]  r;
    logic [AW-1:0]  c;
    logic [AW-1:0]  nr;
    logic [AW-1:0]  nc;
    logic [3:0]     fc;
    logic [1:0]     ri;
    logic [1:0]     rj;
    logic [1:0]     ni;
    logic [1:0]     nj;
    logic [WCW-1:0] wait_cnt;
    logic           last_col;
    logic           last_row;

    function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] row,
                                               input logic [AW-1:0] col);
        return AW'(row * IMG_W) + col;
    endfunction

    // (ri,rj) is the window offset of the read on rd_addr; (ni,nj) the next one.
    always_comb begin
        nj = (rj == 2'd2) ? 2'd0 : rj + 2'd1;
        ni = (rj == 2'd2) ? ri + 2'd1 : ri;
    end

    assign last_col = (c >= AW'(IMG_W - 3));
    assign last_row = (r >= AW'(IMG_H - 3));

    always_comb begin
        nc = last_col ? '0 : c + AW'(1);
        nr = last_col ? r + AW'(1) : r;
    end

    // conv_proc output is only meaningful in the WRITE cycle, so it is gated by wr_en.
    assign bus.wr_data = bus.wr_en ? bus.w_data : 8'd0;
    assign state_dbg   = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            r            <= '0;
            c            <= '0;
            fc           <= '0;
            ri           <= '0;
            rj           <= '0;
            wait_cnt     <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rd_en    <= 1'b0;
            bus.rd_addr  <= '0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.data_mat <= '0;
            bus.kernal   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.k_we && (bus.k_addr <= 4'd8)) begin
                        bus.kernal[bus.k_addr] <= bus.k_data;
                    end
                    if (bus.start) begin
                        state       <= S_FETCH;
                        bus.busy    <= 1'b1;
                        r           <= '0;
                        c           <= '0;
                        fc          <= '0;
                        ri          <= '0;
                        rj          <= '0;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= '0;
                    end
                end

                S_FETCH: begin
                    // Shift-in leaves the first fetched pixel at index 0 after nine captures.
                    if (fc != 4'd0) begin
                        bus.data_mat <= {bus.rd_data, bus.data_mat[8:1]};
                    end
                    if (fc < 4'd8) begin
                        bus.rd_addr <= pix_addr(r + AW'(ni), c + AW'(nj));
                        ri          <= ni;
                        rj          <= nj;
                    end else begin
                        bus.rd_en <= 1'b0;
                    end
                    fc <= fc + 4'd1;
                    if (fc == 4'd9) begin
                        if (PROC_LAT == 0) begin
                            state       <= S_WRITE;
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= AW'(r * (IMG_W - 2)) + c;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end

                S_WAIT: begin
                    if (int'(wait_cnt) == PROC_LAT - 1) begin
                        state       <= S_WRITE;
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= AW'(r * (IMG_W - 2)) + c;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end

                S_WRITE: begin
                    bus.wr_en <= 1'b0;
                    if (last_col && last_row) begin
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state       <= S_FETCH;
                        r           <= nr;
                        c           <= nc;
                        fc          <= '0;
                        ri          <= '0;
                        rj          <= '0;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= pix_addr(nr, nc);
                    end
                end

                S_DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
